// File: rtl/sudoku_pkg.sv
// Shared types and helpers for the sudoku move checker.
// Grid geometry, cell/coordinate types, checker states and scan kinds.
package sudoku_pkg;

  localparam int GRID_N  = 9;
  localparam int BOX_N   = 3;
  localparam int CELL_W  = 4;
  localparam int COORD_W = 4;

  localparam logic [4:0] CNT_MAX = 5'd27;

  typedef logic [CELL_W-1:0]  cell_t;
  typedef logic [COORD_W-1:0] coord_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN_ROW,
    ST_SCAN_COL,
    ST_SCAN_BOX,
    ST_FINISH
  } chk_state_t;

  typedef enum logic [1:0] {
    SK_ROW,
    SK_COL,
    SK_BOX
  } scan_kind_t;

  // Top-left coordinate of the 3x3 box containing c.
  function automatic coord_t box_base(input coord_t c);
    return (c / coord_t'(BOX_N)) * coord_t'(BOX_N);
  endfunction

endpackage

// File: rtl/sudoku_scan_addr_gen.sv
// Combinational grid read address for the current scan kind and index.
// Row: (i, y); column: (x, i); box: row-major walk of the 3x3 box holding (x, y).
module sudoku_scan_addr_gen
  import sudoku_pkg::*;
(
  input  scan_kind_t  kind_i,
  input  logic [3:0]  idx_i,
  input  coord_t      req_x_i,
  input  coord_t      req_y_i,
  output coord_t      rd_x_o,
  output coord_t      rd_y_o
);

  coord_t col_off;
  coord_t row_off;

  always_comb begin
    col_off = coord_t'(idx_i % 4'd3);
    row_off = coord_t'(idx_i / 4'd3);
    rd_x_o  = box_base(req_x_i) + col_off;
    rd_y_o  = box_base(req_y_i) + row_off;
    case (kind_i)
      SK_ROW: begin
        rd_x_o = idx_i;
        rd_y_o = req_y_i;
      end
      SK_COL: begin
        rd_x_o = req_x_i;
        rd_y_o = idx_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/sudoku_move_checker.sv
// Sequential legality checker for a candidate (x, y, value) move.
// Define MOVE_CHECK_EARLY_EXIT_EN to stop scanning at the first counted collision.
module sudoku_move_checker #(
  parameter int GRID_N  = 9,
  parameter int CELL_W  = 4,
  parameter int COORD_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [COORD_W-1:0] req_x,
  input  logic [COORD_W-1:0] req_y,
  input  logic [CELL_W-1:0]  req_value,
  output logic               rd_req,
  input  logic               rd_gnt,
  output logic [COORD_W-1:0] rd_x,
  output logic [COORD_W-1:0] rd_y,
  input  logic [CELL_W-1:0]  rd_data,
  output logic               busy,
  output logic               done,
  output logic               conflict,
  output logic [COORD_W-1:0] conflict_x,
  output logic [COORD_W-1:0] conflict_y,
  output logic [4:0]         conflict_count,
  output logic               range_err
);

  import sudoku_pkg::*;

  chk_state_t state_q;
  chk_state_t next_scan_d;
  scan_kind_t kind;
  logic [3:0] idx_q;
  coord_t     x_q, y_q, cx_q, cy_q, gen_x, gen_y;
  cell_t      val_q;
  logic [4:0] cnt_q;
  logic       conflict_q, range_q;
  logic       scanning, is_self, hit, last_idx, req_bad;

  always_comb begin
    kind        = SK_ROW;
    next_scan_d = ST_FINISH;
    scanning    = 1'b0;
    case (state_q)
      ST_SCAN_ROW: begin
        kind        = SK_ROW;
        next_scan_d = ST_SCAN_COL;
        scanning    = 1'b1;
      end
      ST_SCAN_COL: begin
        kind        = SK_COL;
        next_scan_d = ST_SCAN_BOX;
        scanning    = 1'b1;
      end
      ST_SCAN_BOX: begin
        kind        = SK_BOX;
        next_scan_d = ST_FINISH;
        scanning    = 1'b1;
      end
      default: ;
    endcase
  end

  sudoku_scan_addr_gen u_addr_gen (
    .kind_i  (kind),
    .idx_i   (idx_q),
    .req_x_i (x_q),
    .req_y_i (y_q),
    .rd_x_o  (gen_x),
    .rd_y_o  (gen_y)
  );

  // The target cell itself is read like any other but never counts as a collision.
  assign is_self  = (gen_x == x_q) && (gen_y == y_q);
  assign hit      = scanning && rd_gnt && !is_self && (rd_data == val_q);
  assign last_idx = (idx_q == 4'(GRID_N - 1));
  assign req_bad  = (req_x > COORD_W'(GRID_N - 1)) || (req_y > COORD_W'(GRID_N - 1)) ||
                    (req_value > CELL_W'(GRID_N));

  assign req_ready      = (state_q == ST_IDLE);
  assign rd_req         = scanning;
  assign busy           = scanning;
  assign done           = (state_q == ST_FINISH);
  assign rd_x           = scanning ? gen_x : '0;
  assign rd_y           = scanning ? gen_y : '0;
  assign conflict       = conflict_q;
  assign conflict_x     = cx_q;
  assign conflict_y     = cy_q;
  assign conflict_count = cnt_q;
  assign range_err      = range_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      x_q        <= '0;
      y_q        <= '0;
      val_q      <= '0;
      conflict_q <= 1'b0;
      cx_q       <= '0;
      cy_q       <= '0;
      cnt_q      <= '0;
      range_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            x_q        <= req_x;
            y_q        <= req_y;
            val_q      <= req_value;
            idx_q      <= '0;
            conflict_q <= 1'b0;
            cx_q       <= '0;
            cy_q       <= '0;
            cnt_q      <= '0;
            range_q    <= req_bad;
            state_q    <= (req_bad || req_value == '0) ? ST_FINISH : ST_SCAN_ROW;
          end
        end
        ST_SCAN_ROW, ST_SCAN_COL, ST_SCAN_BOX: begin
          // Address holds and the index only moves on a granted cycle.
          if (rd_gnt) begin
            if (hit) begin
              if (!conflict_q) begin
                conflict_q <= 1'b1;
                cx_q       <= gen_x;
                cy_q       <= gen_y;
              end
              if (cnt_q != CNT_MAX) cnt_q <= cnt_q + 5'd1;
            end
`ifdef MOVE_CHECK_EARLY_EXIT_EN
            if (hit) begin
              idx_q   <= '0;
              state_q <= ST_FINISH;
            end else if (last_idx) begin
              idx_q   <= '0;
              state_q <= next_scan_d;
            end else begin
              idx_q <= idx_q + 4'd1;
            end
`else
            if (last_idx) begin
              idx_q   <= '0;
              state_q <= next_scan_d;
            end else begin
              idx_q <= idx_q + 4'd1;
            end
`endif
          end
        end
        ST_FINISH: state_q <= ST_IDLE;
        default:   state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
